sprite_mover: RTL and testbench

//  Parametrised player-controlled rectangular sprite for the 640x480 VGA game field.
//  - Watches the pixel stream and records obstacles in a probe band STEP pixels thick around the sprite.
//  - Once per frame (on move), moves STEP pixels per axis in the commanded direction(s), unless blocked or at the screen edge.
//  - Feeds the pixel mux (draw) and game logic (xloc/yloc, blocked, moved).

---
 rtl/sprite_mover.sv | 210 +++++++++++++++++++++
 tb/tb_sprite_mover.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mover.sv
// sprite_mover: player-controlled rectangular sprite for the 640x480 game field.
// Watches the pixel stream for obstacles in a probe band around the sprite.
// On each accepted move strobe it steps the sprite, unless it is blocked or at an edge.
// Optional build macro SPRITE_WRAP_EN: horizontal edges wrap instead of clamping.
module sprite_mover #(
  parameter int X_START  = 100,
  parameter int Y_START  = 460,
  parameter int HALF_W   = 4,
  parameter int HALF_H   = 4,
  parameter int STEP     = 1,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixpulse,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       empty,
  input  logic       move,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic       draw,
  output logic [9:0] xloc,
  output logic [9:0] yloc,
  output logic [3:0] blocked,
  output logic       moved
);

  typedef enum logic {
    SCAN  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Obstacle flags gathered during one SCAN: four sides, then the four diagonal corners.
  typedef struct packed {
    logic up;
    logic dn;
    logic lf;
    logic rt;
    logic ul;
    logic ur;
    logic dl;
    logic dr;
  } probe_t;

  // Probe and move arithmetic is done in 12-bit signed form.
  // Bands that reach past the screen edge then simply go negative instead of wrapping.
  localparam logic signed [11:0] HW    = 12'(HALF_W);
  localparam logic signed [11:0] HH    = 12'(HALF_H);
  localparam logic signed [11:0] ST    = 12'(STEP);
  localparam logic signed [11:0] ONE   = 12'sd1;
  localparam logic signed [11:0] X_MIN = 12'(HALF_W);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1 - HALF_W);
  localparam logic signed [11:0] Y_MIN = 12'(HALF_H);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1 - HALF_H);

  // Where a horizontal step that overshoots an edge lands.
`ifdef SPRITE_WRAP_EN
  localparam logic signed [11:0] X_UNDER_LAND = X_MAX;
  localparam logic signed [11:0] X_OVER_LAND  = X_MIN;
`else
  localparam logic signed [11:0] X_UNDER_LAND = X_MIN;
  localparam logic signed [11:0] X_OVER_LAND  = X_MAX;
`endif

  localparam logic [10:0] HW11 = 11'(HALF_W);
  localparam logic [10:0] HH11 = 11'(HALF_H);

  state_t state, state_next;
  probe_t probe, probe_hit;

  logic signed [11:0] h_s, v_s, x_s, y_s;
  logic signed [11:0] x_dec, x_inc, y_dec, y_inc, x_new, y_new;
  logic x_body, x_left, x_right, y_body, y_above, y_below;
  logic go_up, go_dn, go_lf, go_rt;
  logic corner_stop, hold_x, hold_y, pos_changed, accept;
  logic [10:0] h11, v11, x11, y11;

  assign h_s = $signed({2'b00, hcount});
  assign v_s = $signed({2'b00, vcount});
  assign x_s = $signed({2'b00, xloc});
  assign y_s = $signed({2'b00, yloc});

  // The rectangle test uses 11-bit sums, so a sprite near column or row 0 cannot underflow.
  assign h11  = {1'b0, hcount};
  assign v11  = {1'b0, vcount};
  assign x11  = {1'b0, xloc};
  assign y11  = {1'b0, yloc};
  assign draw = (h11 + HW11 >= x11) && (h11 <= x11 + HW11) &&
                (v11 + HH11 >= y11) && (v11 <= y11 + HH11);

  assign accept = pixpulse && (state == SCAN) && move;

  // Classify the current pixel against the sprite body and the STEP-deep bands around it.
  always_comb begin
    x_body  = (h_s >= x_s - HW)       && (h_s <= x_s + HW);
    x_left  = (h_s >= x_s - HW - ST)  && (h_s <= x_s - HW - ONE);
    x_right = (h_s >= x_s + HW + ONE) && (h_s <= x_s + HW + ST);
    y_body  = (v_s >= y_s - HH)       && (v_s <= y_s + HH);
    y_above = (v_s >= y_s - HH - ST)  && (v_s <= y_s - HH - ONE);
    y_below = (v_s >= y_s + HH + ONE) && (v_s <= y_s + HH + ST);

    probe_hit.up = x_body  & y_above;
    probe_hit.dn = x_body  & y_below;
    probe_hit.lf = x_left  & y_body;
    probe_hit.rt = x_right & y_body;
    probe_hit.ul = x_left  & y_above;
    probe_hit.ur = x_right & y_above;
    probe_hit.dl = x_left  & y_below;
    probe_hit.dr = x_right & y_below;
  end

  // Decode the commands and work out the next position from the flags gathered this frame.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    x_new = x_s;
    y_new = y_s;

    go_up = up & ~down;
    go_dn = down & ~up;
    go_lf = left & ~right;
    go_rt = right & ~left;

    // A diagonal move whose two sides are clear must still not slip past a corner obstacle.
    corner_stop = (go_up & go_lf & ~probe.up & ~probe.lf & probe.ul) |
                  (go_up & go_rt & ~probe.up & ~probe.rt & probe.ur) |
                  (go_dn & go_lf & ~probe.dn & ~probe.lf & probe.dl) |
                  (go_dn & go_rt & ~probe.dn & ~probe.rt & probe.dr);

    hold_y = corner_stop | (go_up & probe.up) | (go_dn & probe.dn);
    hold_x = corner_stop | (go_lf & probe.lf) | (go_rt & probe.rt);

    x_dec = x_s - ST;
    x_inc = x_s + ST;
    y_dec = y_s - ST;
    y_inc = y_s + ST;

    if (go_lf && !hold_x) begin
      x_new = (x_dec < X_MIN) ? X_UNDER_LAND : x_dec;
    end else if (go_rt && !hold_x) begin
      x_new = (x_inc > X_MAX) ? X_OVER_LAND : x_inc;
    end

    // The vertical axis always clamps; a partial step lands exactly on the limit.
    if (go_up && !hold_y) begin
      y_new = (y_dec < Y_MIN) ? Y_MIN : y_dec;
    end else if (go_dn && !hold_y) begin
      y_new = (y_inc > Y_MAX) ? Y_MAX : y_inc;
    end

    pos_changed = (x_new != x_s) || (y_new != y_s);
  end

  // FSM state register; it only advances on pixel-enable edges.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples its inputs before any of them update on the same edge.
    if (rst) begin
      state <= SCAN;
    end else if (pixpulse) begin
      state <= state_next;
    end
  end

  // FSM next state: SCAN until a move is accepted, then one CLEAR pixel.
  always_comb begin
    state_next = state;
    case (state)
      SCAN:    if (move) state_next = CLEAR;
      CLEAR:   state_next = SCAN;
      default: state_next = SCAN;
    endcase
  end

  // Probe flags collect obstacle pixels during SCAN and are wiped in CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe <= '0;
    end else if (pixpulse) begin
      if (state == CLEAR) begin
        probe <= '0;
      end else if (!move && !empty) begin
        probe <= probe_t'(probe | probe_hit);
      end
    end
  end

  // Position, blocked flags and the one-clk moved pulse, updated on the move edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xloc    <= 10'(X_START);
      yloc    <= 10'(Y_START);
      blocked <= 4'b0000;
      moved   <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (accept) begin
        xloc    <= x_new[9:0];
        yloc    <= y_new[9:0];
        blocked <= {probe.up, probe.dn, probe.lf, probe.rt};
        moved   <= pos_changed;
      end
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Testbench for sprite_mover: two instances (STEP=1 and STEP=3) share one pixel stream.
// Expected positions come from a pixel-set reference model; a monitor pops them on each move.
module tb_sprite_mover;

  localparam int HW   = 4;
  localparam int HH   = 4;
  localparam int SW   = 640;
  localparam int SH   = 480;
  localparam int XS   = 100;
  localparam int YS   = 460;
  localparam int XMAX = SW - 1 - HW;
  localparam int YMAX = SH - 1 - HH;
`ifdef SPRITE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_RIGHT = 4'b0001;
  localparam logic [3:0] C_LEFT  = 4'b0010;
  localparam logic [3:0] C_DOWN  = 4'b0100;
  localparam logic [3:0] C_UP    = 4'b1000;

  logic       clk = 1'b0;
  logic       rst, pixpulse, empty, move, up, down, left, right;
  logic [9:0] hcount, vcount;
  logic       draw_o    [2];
  logic [9:0] xloc_o    [2];
  logic [9:0] yloc_o    [2];
  logic [3:0] blocked_o [2];
  logic       moved_o   [2];

  sprite_mover #(.STEP(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .empty(empty), .move(move), .up(up), .down(down), .left(left), .right(right),
    .draw(draw_o[0]), .xloc(xloc_o[0]), .yloc(yloc_o[0]), .blocked(blocked_o[0]),
    .moved(moved_o[0])
  );

  sprite_mover #(.STEP(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .empty(empty), .move(move), .up(up), .down(down), .left(left), .right(right),
    .draw(draw_o[1]), .xloc(xloc_o[1]), .yloc(yloc_o[1]), .blocked(blocked_o[1]),
    .moved(moved_o[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    int         x;
    int         y;
    logic [3:0] blk;
    logic       mv;
  } exp_t;

  typedef struct {
    int h;
    int v;
  } pix_t;

  exp_t sb[$];
  pix_t obs[$];
  int   mx[2];
  int   my[2];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Flags {up,dn,lf,rt,ul,ur,dl,dr} from the obstacle pixels seen since the last move,
  // judged by each pixel's offset from the sprite centre.
  function automatic logic [7:0] model_flags(input int x, input int y, input int st);
    logic [7:0] f;
    int dx, dy;
    bit in_x, in_y, lft, rgt, abv, blw;
    f = '0;
    foreach (obs[k]) begin
      dx   = obs[k].h - x;
      dy   = obs[k].v - y;
      in_x = (dx >= -HW) && (dx <= HW);
      in_y = (dy >= -HH) && (dy <= HH);
      lft  = (dx < -HW) && (dx >= -HW - st);
      rgt  = (dx > HW)  && (dx <= HW + st);
      abv  = (dy < -HH) && (dy >= -HH - st);
      blw  = (dy > HH)  && (dy <= HH + st);
      f[7] |= in_x & abv;
      f[6] |= in_x & blw;
      f[5] |= lft & in_y;
      f[4] |= rgt & in_y;
      f[3] |= lft & abv;
      f[2] |= rgt & abv;
      f[1] |= lft & blw;
      f[0] |= rgt & blw;
    end
    return f;
  endfunction

  // Reference move for one instance; pushes the expected outcome and updates the model.
  task automatic model_move(input int i, input logic [3:0] cmd);
    int st, vd, hd, nx, ny;
    bit bv, bh, corner;
    logic [7:0] f;
    exp_t e;
    st = step_of(i);
    f  = model_flags(mx[i], my[i], st);
    vd = (cmd[3] && !cmd[2]) ? -1 : (cmd[2] && !cmd[3]) ? 1 : 0;
    hd = (cmd[1] && !cmd[0]) ? -1 : (cmd[0] && !cmd[1]) ? 1 : 0;
    bv = (vd < 0 && f[7]) || (vd > 0 && f[6]);
    bh = (hd < 0 && f[5]) || (hd > 0 && f[4]);
    corner = 1'b0;
    if (vd != 0 && hd != 0 && !bv && !bh)
      corner = (vd < 0 && hd < 0) ? f[3] : (vd < 0) ? f[2] : (hd < 0) ? f[1] : f[0];
    nx = mx[i];
    ny = my[i];
    if (!corner && !bv && vd != 0) begin
      ny = my[i] + vd * st;
      if (ny < HH)   ny = HH;
      if (ny > YMAX) ny = YMAX;
    end
    if (!corner && !bh && hd != 0) begin
      nx = mx[i] + hd * st;
      if (nx < HW)        nx = WRAP ? XMAX : HW;
      else if (nx > XMAX) nx = WRAP ? HW : XMAX;
    end
    e.inst = i;
    e.x    = nx;
    e.y    = ny;
    e.blk  = f[7:4];
    e.mv   = (nx != mx[i]) || (ny != my[i]);
    sb.push_back(e);
    mx[i] = nx;
    my[i] = ny;
  endtask

  // One pixel with pixpulse high for one clk, then three idle clks.
  task automatic pix(input int h, input int v, input logic e, input logic mv, input logic [3:0] cmd);
    @(negedge clk);
    hcount   = 10'(h);
    vcount   = 10'(v);
    empty    = e;
    move     = mv;
    {up, down, left, right} = cmd;
    pixpulse = 1'b1;
    @(negedge clk);
    pixpulse = 1'b0;
    move     = 1'b0;
    empty    = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic scan_px(input int h, input int v, input logic e);
    pix_t p;
    if (!e) begin
      p.h = h;
      p.v = v;
      obs.push_back(p);
    end
    pix(h, v, e, 1'b0, 4'($urandom));
  endtask

  function automatic int clip(input int a, input int lo, input int hi);
    return (a < lo) ? lo : (a > hi) ? hi : a;
  endfunction

  // Accepted move, followed by a CLEAR pixel carrying junk that must be ignored.
  task automatic do_move(input logic [3:0] cmd);
    int ch, cv;
    model_move(0, cmd);
    model_move(1, cmd);
    obs.delete();
    pix(int'($urandom_range(0, SW - 1)), int'($urandom_range(0, SH - 1)), 1'b1, 1'b1, cmd);
    ch = clip(mx[0] + HW + 1, 0, SW - 1);
    cv = clip(my[0], 0, SH - 1);
    pix(ch, cv, 1'($urandom), 1'($urandom), 4'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    mx  = '{XS, XS};
    my  = '{YS, YS};
    obs.delete();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_x[%0d]", i), 32'(xloc_o[i]), 32'(XS));
      check($sformatf("rst_y[%0d]", i), 32'(yloc_o[i]), 32'(YS));
      check($sformatf("rst_blk[%0d]", i), 32'(blocked_o[i]), 32'd0);
      check($sformatf("rst_moved[%0d]", i), 32'(moved_o[i]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_draw(input int h, input int v);
    bit exp;
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    #1;
    for (int i = 0; i < 2; i++) begin
      exp = (h >= mx[i] - HW) && (h <= mx[i] + HW) && (v >= my[i] - HH) && (v <= my[i] + HH);
      check($sformatf("draw[%0d](%0d,%0d)", i, h, v), 32'(draw_o[i]), 32'(exp));
    end
  endtask

  // Monitor: tracks SCAN/CLEAR from the bus and compares on every accepted move.
  initial begin : monitor
    bit   in_clear;
    exp_t e;
    in_clear = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        in_clear = 1'b0;
      end else if (pixpulse) begin
        if (in_clear) begin
          in_clear = 1'b0;
        end else if (move) begin
          in_clear = 1'b1;
          #1;
          for (int k = 0; k < 2; k++) begin
            if (sb.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL sb_empty: got no expected entry, required one per instance");
            end else begin
              e = sb.pop_front();
              check($sformatf("x[%0d]", e.inst), 32'(xloc_o[e.inst]), 32'(e.x));
              check($sformatf("y[%0d]", e.inst), 32'(yloc_o[e.inst]), 32'(e.y));
              check($sformatf("blk[%0d]", e.inst), 32'(blocked_o[e.inst]), 32'(e.blk));
              check($sformatf("moved[%0d]", e.inst), 32'(moved_o[e.inst]), 32'(e.mv));
            end
          end
          @(posedge clk);
          #1;
          check("moved_drop[0]", 32'(moved_o[0]), 32'd0);
          check("moved_drop[1]", 32'(moved_o[1]), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n_px, oi, h, v;
    rst = 1'b1; pixpulse = 1'b0; empty = 1'b1; move = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    hcount = '0; vcount = '0;
    repeat (2) @(negedge clk);

    // Reset state and the drawn rectangle.
    do_reset();
    chk_draw(96, 456);
    chk_draw(104, 464);
    chk_draw(95, 460);
    chk_draw(100, 465);

    // Free move right.
    do_move(C_RIGHT);
    check("free_x_s1", 32'(xloc_o[0]), 32'd101);
    check("free_x_s3", 32'(xloc_o[1]), 32'd103);

    // Obstacle directly right of the sprite.
    do_reset();
    scan_px(105, 460, 1'b0);
    do_move(C_RIGHT);
    check("obst_blk", 32'(blocked_o[0]), 32'b0001);

    // Corner obstacle at upper right: up+right holds both axes, up+left is free.
    do_reset();
    scan_px(105, 455, 1'b0);
    do_move(C_UP | C_RIGHT);
    do_reset();
    scan_px(105, 455, 1'b0);
    do_move(C_UP | C_LEFT);
    check("corner_ul_x", 32'(xloc_o[0]), 32'd99);
    check("corner_ul_y", 32'(yloc_o[0]), 32'd459);

    // Walk to the left edge and past it, then to the bottom edge.
    do_reset();
    for (int i = 0; i < 96; i++) do_move(C_LEFT);
    check("edge_x_min", 32'(xloc_o[0]), 32'(HW));
    do_move(C_LEFT);
    check("edge_x_past", 32'(xloc_o[0]), WRAP ? 32'(XMAX) : 32'(HW));
    if (WRAP) do_move(C_RIGHT);
    for (int i = 0; i < 16; i++) do_move(C_DOWN);
    check("edge_y_max", 32'(yloc_o[0]), 32'(YMAX));

    // Opposing commands, then a reset in the middle of a scan with flags set.
    do_move(C_UP | C_DOWN);
    do_move(C_NONE);
    do_reset();
    scan_px(105, 460, 1'b0);
    scan_px(100, 455, 1'b0);
    do_reset();
    do_move(C_RIGHT);
    check("post_rst_x", 32'(xloc_o[0]), 32'd101);

    // Randomised frames: obstacle pixels scattered around either sprite.
    for (int f = 0; f < 200; f++) begin
      n_px = int'($urandom_range(0, 6));
      for (int p = 0; p < n_px; p++) begin
        oi = int'($urandom_range(0, 1));
        h  = clip(mx[oi] + int'($urandom_range(0, 2 * (HW + 4))) - (HW + 4), 0, SW - 1);
        v  = clip(my[oi] + int'($urandom_range(0, 2 * (HH + 4))) - (HH + 4), 0, SH - 1);
        scan_px(h, v, ($urandom_range(0, 9) < 6));
      end
      do_move(4'($urandom));
      if (f % 8 == 0) begin
        oi = int'($urandom_range(0, 1));
        chk_draw(clip(mx[oi] + int'($urandom_range(0, 12)) - 6, 0, SW - 1),
                 clip(my[oi] + int'($urandom_range(0, 12)) - 6, 0, SH - 1));
      end
    end

    repeat (8) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
